// File: rtl/ysyx_24100005_lsu.sv
// ysyx_24100005_lsu: registered, handshaked load/store unit with lane alignment, load extension and error reporting
module ysyx_24100005_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic wen_r, err_r, legal, aligned, bad, timeout;
  logic [2:0] f3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r, shifted, ld_data, size_mask;
  logic [NB-1:0] byte_mask;
  logic [OW-1:0] off;
  logic [CW-1:0] cnt;
  always_comb begin
    legal = req_wen ? (req_funct3 <= 3'd2 || (req_funct3 == 3'd3 && DATA_W == 64))
                    : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} ||
                       (DATA_W == 64 && (req_funct3 == 3'd3 || req_funct3 == 3'd6)));
    aligned = req_funct3[1:0] == 2'd0 ||
              (req_funct3[1:0] == 2'd1 && !req_addr[0]) ||
              (req_funct3[1:0] == 2'd2 && req_addr[1:0] == 2'd0) ||
              (req_funct3[1:0] == 2'd3 && req_addr[2:0] == 3'd0);
    bad = !legal || !aligned;
  end
  always_comb begin
    off = addr_r[OW-1:0];
    shifted = mem_rdata >> {off, 3'b000};
    ld_data = f3_r == 3'd0 ? DATA_W'($signed(shifted[7:0])) :
              f3_r == 3'd1 ? DATA_W'($signed(shifted[15:0])) :
              f3_r == 3'd2 ? DATA_W'($signed(shifted[31:0])) :
              f3_r == 3'd4 ? DATA_W'(shifted[7:0]) :
              f3_r == 3'd5 ? DATA_W'(shifted[15:0]) :
              f3_r == 3'd6 ? DATA_W'(shifted[31:0]) : shifted;
    size_mask = f3_r[1:0] == 2'd0 ? DATA_W'(64'hFF) :
                f3_r[1:0] == 2'd1 ? DATA_W'(64'hFFFF) :
                f3_r[1:0] == 2'd2 ? DATA_W'(64'hFFFF_FFFF) : '1;
    byte_mask = f3_r[1:0] == 2'd0 ? NB'(8'h01) :
                f3_r[1:0] == 2'd1 ? NB'(8'h03) :
                f3_r[1:0] == 2'd2 ? NB'(8'h0F) : NB'(8'hFF);
    timeout = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE  ? (req_valid ? (bad ? DONE : ISSUE) : IDLE) :
          state == ISSUE ? (mem_req_ready ? WAIT : ISSUE) :
          state == WAIT  ? ((mem_rsp_valid || timeout) ? DONE : WAIT) :
                           (resp_ready ? IDLE : DONE);
  always_comb begin
    req_ready = !rst && state == IDLE;
    mem_req_valid = !rst && state == ISSUE;
    resp_valid = !rst && state == DONE;
    resp_err = resp_valid && err_r;
    resp_rdata = resp_valid ? rdata_r : '0;
    mem_wen = !rst && wen_r;
    mem_addr = rst ? '0 : {addr_r[ADDR_W-1:OW], OW'(0)};
    mem_wdata = rst ? '0 : (wdata_r & size_mask) << {off, 3'b000};
    mem_wmask = (rst || !wen_r) ? '0 : byte_mask << off;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_r <= 1'b0;
      err_r <= 1'b0;
      f3_r <= '0;
      addr_r <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        wen_r <= req_wen;
        f3_r <= req_funct3;
        addr_r <= req_addr;
        wdata_r <= req_wdata;
        err_r <= bad;
        rdata_r <= '0;
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (mem_rsp_valid) rdata_r <= wen_r ? '0 : ld_data;
        else if (timeout) err_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// tb_ysyx_24100005_lsu: table-driven and sequence checks of the load/store unit at 32 and 64 bits
module tb_ysyx_24100005_lsu;
  localparam logic [31:0] W32 = 32'h8765_43F1;
  localparam logic [63:0] W64 = 64'hFEDC_BA98_7654_3210;
  logic clk = 0, rst = 1, sel = 0;
  logic req_valid = 0, req_wen = 0, resp_ready = 1, mem_req_ready = 0, mem_rsp_valid = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0;
  logic [63:0] req_wdata = 0, mem_rdata = 0;
  logic rq32, rv32, re32, mv32, mw32, rq64, rv64, re64, mv64, mw64;
  logic [31:0] rd32, ma32, md32, ma64;
  logic [63:0] rd64, md64;
  logic [3:0] mk32;
  logic [7:0] mk64;
  logic o_req_ready, o_resp_valid, o_err, o_mreq, o_mwen;
  logic [63:0] o_rdata, o_mwdata;
  logic [31:0] o_maddr;
  logic [7:0] o_mask;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  ysyx_24100005_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) d32 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rq32), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(rv32), .resp_ready(resp_ready), .resp_rdata(rd32), .resp_err(re32),
    .mem_req_valid(mv32), .mem_req_ready(mem_req_ready), .mem_wen(mw32), .mem_addr(ma32),
    .mem_wdata(md32), .mem_wmask(mk32), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0]));
  ysyx_24100005_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(8)) d64 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rq64), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv64), .resp_ready(resp_ready), .resp_rdata(rd64), .resp_err(re64),
    .mem_req_valid(mv64), .mem_req_ready(mem_req_ready), .mem_wen(mw64), .mem_addr(ma64),
    .mem_wdata(md64), .mem_wmask(mk64), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata));
  assign o_req_ready = sel ? rq64 : rq32;
  assign o_resp_valid = sel ? rv64 : rv32;
  assign o_err = sel ? re64 : re32;
  assign o_mreq = sel ? mv64 : mv32;
  assign o_mwen = sel ? mw64 : mw32;
  assign o_rdata = sel ? rd64 : {32'h0, rd32};
  assign o_mwdata = sel ? md64 : {32'h0, md32};
  assign o_maddr = sel ? ma64 : ma32;
  assign o_mask = sel ? mk64 : {4'h0, mk32};
  typedef struct {
    logic s; logic wen; logic [2:0] f3; logic [31:0] addr; logic [63:0] wdata;
    logic [63:0] rdata; logic err; logic mem; logic [31:0] maddr; logic [7:0] mask; logic [63:0] mwdata;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic txn(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [63:0] d,
                     output logic [63:0] rd, output logic er, output logic saw, output logic [31:0] ma,
                     output logic [7:0] mk, output logic [63:0] mw, output logic mwen, output int ncyc);
    logic pend;
    pend = 0; saw = 0; rd = 0; er = 0; ma = 0; mk = 0; mw = 0; mwen = 0; ncyc = 0;
    @(negedge clk);
    req_valid = 1; req_wen = w; req_funct3 = f; req_addr = a; req_wdata = d; resp_ready = 1;
    @(posedge clk);
    #1 req_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      mem_rsp_valid = 0;
      if (o_resp_valid) begin
        rd = o_rdata; er = o_err; ncyc = i;
        break;
      end
      if (o_mreq) begin
        saw = 1; ma = o_maddr; mk = o_mask; mw = o_mwdata; mwen = o_mwen;
        mem_req_ready = 1; pend = 1;
      end else if (pend) begin
        mem_req_ready = 0; mem_rsp_valid = 1; pend = 0;
        mem_rdata = sel ? W64 : {32'h0, W32};
      end
    end
    mem_rsp_valid = 0; mem_req_ready = 0;
    @(posedge clk);
  endtask
  initial begin
    logic [63:0] rd, mw;
    logic er, saw, mwen;
    logic [31:0] ma;
    logic [7:0] mk;
    int n;
    v.push_back('{0, 0, 3'd0, 32'h8000_0010, 64'h0, 64'hFFFF_FFF1, 0, 1, 32'h8000_0010, 8'h0, 64'h0});
    v.push_back('{0, 0, 3'd4, 32'h8000_0010, 64'h0, 64'h0000_00F1, 0, 1, 32'h8000_0010, 8'h0, 64'h0});
    v.push_back('{0, 0, 3'd0, 32'h8000_0011, 64'h0, 64'h0000_0043, 0, 1, 32'h8000_0010, 8'h0, 64'h0});
    v.push_back('{0, 0, 3'd1, 32'h8000_0012, 64'h0, 64'hFFFF_8765, 0, 1, 32'h8000_0010, 8'h0, 64'h0});
    v.push_back('{0, 0, 3'd5, 32'h8000_0012, 64'h0, 64'h0000_8765, 0, 1, 32'h8000_0010, 8'h0, 64'h0});
    v.push_back('{0, 0, 3'd2, 32'h8000_0010, 64'h0, 64'h8765_43F1, 0, 1, 32'h8000_0010, 8'h0, 64'h0});
    v.push_back('{0, 0, 3'd5, 32'h8000_0010, 64'h0, 64'h0000_43F1, 0, 1, 32'h8000_0010, 8'h0, 64'h0});
    v.push_back('{0, 1, 3'd0, 32'h8000_0013, 64'h1234_56AB, 64'h0, 0, 1, 32'h8000_0010, 8'h8, 64'hAB00_0000});
    v.push_back('{0, 1, 3'd1, 32'h8000_0012, 64'h1234_56AB, 64'h0, 0, 1, 32'h8000_0010, 8'hC, 64'h56AB_0000});
    v.push_back('{0, 1, 3'd2, 32'h8000_0010, 64'h1234_56AB, 64'h0, 0, 1, 32'h8000_0010, 8'hF, 64'h1234_56AB});
    v.push_back('{0, 0, 3'd2, 32'h8000_0002, 64'h0, 64'h0, 1, 0, 32'h0, 8'h0, 64'h0});
    v.push_back('{0, 0, 3'd3, 32'h8000_0010, 64'h0, 64'h0, 1, 0, 32'h0, 8'h0, 64'h0});
    v.push_back('{0, 0, 3'd1, 32'h8000_0011, 64'h0, 64'h0, 1, 0, 32'h0, 8'h0, 64'h0});
    v.push_back('{0, 0, 3'd6, 32'h8000_0010, 64'h0, 64'h0, 1, 0, 32'h0, 8'h0, 64'h0});
    v.push_back('{0, 1, 3'd4, 32'h8000_0010, 64'h0, 64'h0, 1, 0, 32'h0, 8'h0, 64'h0});
    v.push_back('{1, 0, 3'd2, 32'h8000_000C, 64'h0, 64'hFFFF_FFFF_FEDC_BA98, 0, 1, 32'h8000_0008, 8'h0, 64'h0});
    v.push_back('{1, 0, 3'd6, 32'h8000_000C, 64'h0, 64'h0000_0000_FEDC_BA98, 0, 1, 32'h8000_0008, 8'h0, 64'h0});
    v.push_back('{1, 1, 3'd3, 32'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 0, 1, 32'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788});
    v.push_back('{1, 0, 3'd3, 32'h8000_0008, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 1, 32'h8000_0008, 8'h0, 64'h0});
    v.push_back('{1, 0, 3'd2, 32'h8000_0008, 64'h0, 64'h0000_0000_7654_3210, 0, 1, 32'h8000_0008, 8'h0, 64'h0});
    v.push_back('{1, 1, 3'd2, 32'h8000_000C, 64'hAABB_CCDD, 64'h0, 0, 1, 32'h8000_0008, 8'hF0, 64'hAABB_CCDD_0000_0000});
    v.push_back('{1, 0, 3'd0, 32'h8000_000F, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 32'h8000_0008, 8'h0, 64'h0});
    v.push_back('{1, 0, 3'd7, 32'h8000_0008, 64'h0, 64'h0, 1, 0, 32'h0, 8'h0, 64'h0});
    v.push_back('{1, 0, 3'd2, 32'h8000_000A, 64'h0, 64'h0, 1, 0, 32'h0, 8'h0, 64'h0});
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {63'h0, o_req_ready}, 64'h0);
    chk("rst_resp_valid", {63'h0, o_resp_valid}, 64'h0);
    chk("rst_mem_req_valid", {63'h0, o_mreq}, 64'h0);
    chk("rst_mem_addr", {32'h0, o_maddr}, 64'h0);
    rst = 0;
    #1 chk("post_rst_req_ready", {63'h0, o_req_ready}, 64'h1);
    foreach (v[i]) begin
      sel = v[i].s;
      txn(v[i].wen, v[i].f3, v[i].addr, v[i].wdata, rd, er, saw, ma, mk, mw, mwen, n);
      chk($sformatf("v%0d_rdata", i), rd, v[i].rdata);
      chk($sformatf("v%0d_err", i), {63'h0, er}, {63'h0, v[i].err});
      chk($sformatf("v%0d_mem_req", i), {63'h0, saw}, {63'h0, v[i].mem});
      chk($sformatf("v%0d_latency", i), 64'(n), v[i].err ? 64'd1 : 64'd3);
      if (v[i].mem) begin
        chk($sformatf("v%0d_mem_addr", i), {32'h0, ma}, {32'h0, v[i].maddr});
        chk($sformatf("v%0d_mem_wmask", i), {56'h0, mk}, {56'h0, v[i].mask});
        chk($sformatf("v%0d_mem_wdata", i), mw, v[i].mwdata);
        chk($sformatf("v%0d_mem_wen", i), {63'h0, mwen}, {63'h0, v[i].wen});
      end
    end
    sel = 0;
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_funct3 = 3'd2; req_addr = 32'h8000_0010; resp_ready = 0; mem_req_ready = 0;
    @(posedge clk);
    #1 req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_mem_req_valid", i), {63'h0, o_mreq}, 64'h1);
      chk($sformatf("hold%0d_mem_addr", i), {32'h0, o_maddr}, 64'h8000_0010);
      chk($sformatf("hold%0d_mem_wen", i), {63'h0, o_mwen}, 64'h0);
      chk($sformatf("hold%0d_req_ready", i), {63'h0, o_req_ready}, 64'h0);
    end
    mem_req_ready = 1;
    @(posedge clk);
    #1 mem_req_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk($sformatf("to_cycle%0d_resp_valid", i), {63'h0, o_resp_valid}, {63'h0, i == 9});
    end
    chk("to_err", {63'h0, o_err}, 64'h1);
    chk("to_rdata", o_rdata, 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("resp_hold%0d_valid", i), {63'h0, o_resp_valid}, 64'h1);
      chk($sformatf("resp_hold%0d_err", i), {63'h0, o_err}, 64'h1);
      chk($sformatf("resp_hold%0d_rdata", i), o_rdata, 64'h0);
    end
    resp_ready = 1;
    @(negedge clk);
    chk("resp_release_valid", {63'h0, o_resp_valid}, 64'h0);
    chk("resp_release_req_ready", {63'h0, o_req_ready}, 64'h1);
    req_valid = 1; req_wen = 0; req_funct3 = 3'd2; req_addr = 32'h8000_0010; mem_req_ready = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #1 mem_req_ready = 0; rst = 1;
    @(negedge clk);
    chk("wait_rst_req_ready", {63'h0, o_req_ready}, 64'h0);
    chk("wait_rst_resp_valid", {63'h0, o_resp_valid}, 64'h0);
    chk("wait_rst_mem_req_valid", {63'h0, o_mreq}, 64'h0);
    chk("wait_rst_mem_addr", {32'h0, o_maddr}, 64'h0);
    @(posedge clk);
    #1 rst = 0; mem_rsp_valid = 1; mem_rdata = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("stray_req_ready", {63'h0, o_req_ready}, 64'h1);
    @(posedge clk);
    #1 mem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stray%0d_resp_valid", i), {63'h0, o_resp_valid}, 64'h0);
    end
    txn(0, 3'd2, 32'h8000_0010, 64'h0, rd, er, saw, ma, mk, mw, mwen, n);
    chk("after_rst_lw_rdata", rd, 64'h8765_43F1);
    chk("after_rst_lw_err", {63'h0, er}, 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
